// File: rtl/imem_loader_if.sv
// Load-port and imem-write bundle for the instruction-memory loader.
// The master side drives load bytes; the slave side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 40
);
  logic              load_mode;
  logic [7:0]        byte_in;
  logic              byte_strobe;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              core_hold;
  logic [10:0]       word_count;
  logic [7:0]        checksum;
  logic              err_timeout;
  logic              err_partial;
  logic              err_addr;

  modport master (
    output load_mode, byte_in, byte_strobe,
    input  imem_we, imem_addr, imem_data, core_hold, word_count, checksum,
           err_timeout, err_partial, err_addr
  );

  modport slave (
    input  load_mode, byte_in, byte_strobe,
    output imem_we, imem_addr, imem_data, core_hold, word_count, checksum,
           err_timeout, err_partial, err_addr
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Assembles 7-byte load frames (2 address bytes, 5 data bytes, MSB first)
// from a strobed byte port and issues one imem write per valid frame.
module imem_loader_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk_int,
  input  logic          reset_n,
  imem_loader_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t            state;
  logic [47:0]       asm_q;
  logic [2:0]        idx;
  logic [TW-1:0]     tcnt;
  logic              strobe_prev;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              hold_q;
  logic [10:0]       count_q;
  logic [7:0]        cks_q;
  logic              e_timeout, e_partial, e_addr;

  logic              edge_det;
  logic [55:0]       asm_next;
  logic              addr_ok;

  function automatic logic [7:0] frame_xor(input logic [55:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ f[i*8 +: 8];
    return x;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign edge_det = bus.byte_strobe & ~strobe_prev;
  assign asm_next = {asm_q, bus.byte_in};
  // byte0 sits in the top of the 48 bits already collected when byte 6 arrives
  assign addr_ok  = (asm_q[47:42] == 6'd0);

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      asm_q       <= '0;
      idx         <= '0;
      tcnt        <= '0;
      strobe_prev <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      hold_q      <= 1'b0;
      count_q     <= '0;
      cks_q       <= '0;
      e_timeout   <= 1'b0;
      e_partial   <= 1'b0;
      e_addr      <= 1'b0;
    end else begin
      strobe_prev <= bus.byte_strobe;
      we_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_mode) begin
            state     <= COLLECT;
            hold_q    <= 1'b1;
            count_q   <= '0;
            cks_q     <= '0;
            e_timeout <= 1'b0;
            e_partial <= 1'b0;
            e_addr    <= 1'b0;
            idx       <= '0;
            tcnt      <= '0;
          end
        end
        COLLECT: begin
          if (!bus.load_mode) begin
            if (idx != 3'd0) e_partial <= 1'b1;
            idx    <= '0;
            tcnt   <= '0;
            state  <= IDLE;
            hold_q <= 1'b0;
          end else if (edge_det) begin
            asm_q <= asm_next[47:0];
            tcnt  <= '0;
            if (idx == 3'd6) begin
              idx <= '0;
              if (addr_ok) begin
                state   <= WRITE;
                we_q    <= 1'b1;
                addr_q  <= asm_next[40 +: ADDR_W];
                data_q  <= asm_next[DATA_W-1:0];
                count_q <= sat_inc(count_q);
                cks_q   <= cks_q ^ frame_xor(asm_next);
              end else begin
                e_addr <= 1'b1;
              end
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (idx != 3'd0) begin
            // a stalled partial frame is abandoned after TIMEOUT quiet cycles
            if (tcnt == TW'(TIMEOUT - 1)) begin
              idx       <= '0;
              tcnt      <= '0;
              e_timeout <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        WRITE: begin
          if (!bus.load_mode) begin
            state  <= IDLE;
            hold_q <= 1'b0;
            idx    <= '0;
            tcnt   <= '0;
          end else begin
            state <= COLLECT;
            if (edge_det) begin
              asm_q <= asm_next[47:0];
              idx   <= 3'd1;
              tcnt  <= '0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_we     = we_q;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_data   = data_q;
  assign bus.core_hold   = hold_q;
  assign bus.word_count  = count_q;
  assign bus.checksum    = cks_q;
  assign bus.err_timeout = e_timeout;
  assign bus.err_partial = e_partial;
  assign bus.err_addr    = e_addr;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed and randomized load sequences against a frame-level model of the loader.
module tb_imem_loader_ctrl;

  localparam int TO = 32;

  logic clk_int = 1'b0;
  logic reset_n;
  always #5 clk_int = ~clk_int;

  imem_loader_if #(.ADDR_W(10), .DATA_W(40)) bus();

  imem_loader_ctrl #(.ADDR_W(10), .DATA_W(40), .TIMEOUT(TO)) dut (
    .clk_int (clk_int),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;
  int exp_pulses = 0;

  // model: bytes of the frame in flight, and the writes it still expects
  logic [7:0]  part[$];
  logic [49:0] exp_q[$];
  logic [49:0] mon_e;
  logic [49:0] last_w;
  int          m_count;
  logic [7:0]  m_cks;
  bit          m_eaddr, m_etime, m_epart;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_int) begin
    if (reset_n === 1'b1 && bus.imem_we === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("spurious_we", bus.imem_we, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("imem_addr", bus.imem_addr, mon_e[49:40]);
        chk("imem_data", bus.imem_data, mon_e[39:0]);
        last_w = mon_e;
      end
    end
  end

  task automatic model_clear();
    part.delete();
    m_count = 0;
    m_cks   = 8'h00;
    m_eaddr = 0;
    m_etime = 0;
    m_epart = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0]  x;
    logic [49:0] w;
    part.push_back(b);
    if (part.size() == 7) begin
      if (part[0][7:2] != 6'd0) begin
        m_eaddr = 1;
      end else begin
        x = 8'h00;
        foreach (part[i]) x ^= part[i];
        w = {part[0][1:0], part[1], part[2], part[3], part[4], part[5], part[6]};
        exp_q.push_back(w);
        m_count = (m_count < 2047) ? m_count + 1 : 2047;
        m_cks ^= x;
        exp_pulses++;
      end
      part.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk_int);
    bus.byte_in     = b;
    bus.byte_strobe = 1'b1;
    model_byte(b);
    @(negedge clk_int);
    bus.byte_strobe = 1'b0;
    repeat (gap) @(negedge clk_int);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [39:0] d, input int gap);
    send_byte(b0, gap);
    send_byte(b1, gap);
    for (int i = 4; i >= 0; i--) send_byte(d[i*8 +: 8], gap);
  endtask

  task automatic send_word(input logic [9:0] a, input logic [39:0] d, input int gap);
    send_frame({6'd0, a[9:8]}, a[7:0], d, gap);
  endtask

  task automatic enter_load();
    @(negedge clk_int);
    bus.load_mode = 1'b1;
    model_clear();
    @(negedge clk_int);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"},   bus.word_count,  m_count);
    chk({tag, "_cks"},     bus.checksum,    m_cks);
    chk({tag, "_eaddr"},   bus.err_addr,    m_eaddr);
    chk({tag, "_etime"},   bus.err_timeout, m_etime);
    chk({tag, "_epart"},   bus.err_partial, m_epart);
    chk({tag, "_pulses"},  pulses,          exp_pulses);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    bus.imem_we,     1'b0);
    chk({tag, "_addr"},  bus.imem_addr,   10'd0);
    chk({tag, "_data"},  bus.imem_data,   40'd0);
    chk({tag, "_hold"},  bus.core_hold,   1'b0);
    chk({tag, "_count"}, bus.word_count,  11'd0);
    chk({tag, "_cks"},   bus.checksum,    8'd0);
    chk({tag, "_errs"},  {bus.err_timeout, bus.err_partial, bus.err_addr}, 3'b000);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  ra;
    logic [39:0] rd;
    logic [7:0]  rb0;

    bus.load_mode   = 1'b0;
    bus.byte_in     = 8'h00;
    bus.byte_strobe = 1'b0;
    reset_n         = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_int);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk_int);
    chk("idle_hold", bus.core_hold, 1'b0);

    // reference word
    enter_load();
    chk("load_hold", bus.core_hold, 1'b1);
    send_word(10'h215, 40'hDEADBEEF01, 1);
    repeat (3) @(negedge clk_int);
    chk_status("word1");
    chk("word1_cks_direct", bus.checksum, 8'h34);
    chk("addr_hold", bus.imem_addr, 10'h215);
    chk("data_hold", bus.imem_data, 40'hDEADBEEF01);

    // two words at the fastest strobe rate
    for (int i = 0; i < 2; i++) begin
      ra = 10'($urandom);
      rd = {8'($urandom), 32'($urandom)};
      send_word(ra, rd, 0);
    end
    repeat (3) @(negedge clk_int);
    chk_status("b2b");

    // bad address byte drops the frame
    send_frame(8'h04, 8'($urandom), {8'($urandom), 32'($urandom)}, 1);
    repeat (3) @(negedge clk_int);
    chk_status("bad_addr");

    // stalled partial frame
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    repeat (TO / 2) @(negedge clk_int);
    chk("timeout_early", bus.err_timeout, 1'b0);
    repeat (TO + 4) @(negedge clk_int);
    part.delete();
    m_etime = 1;
    chk_status("timeout");
    send_word(10'h3A5, {8'($urandom), 32'($urandom)}, 1);
    repeat (3) @(negedge clk_int);
    chk_status("after_timeout");

    // leave load mode mid-frame
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    @(negedge clk_int);
    bus.load_mode = 1'b0;
    if (part.size() != 0) m_epart = 1;
    part.delete();
    repeat (3) @(negedge clk_int);
    chk_status("partial");
    chk("partial_hold", bus.core_hold, 1'b0);
    enter_load();
    chk_status("reentry");
    chk("reentry_hold", bus.core_hold, 1'b1);

    // randomized frames, some with a bad address byte
    for (int n = 0; n < 20; n++) begin
      ra = 10'($urandom);
      rd = {8'($urandom), 32'($urandom)};
      rb0 = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(4, 255)) : {6'd0, ra[9:8]};
      send_frame(rb0, ra[7:0], rd, $urandom_range(0, 3));
    end
    repeat (3) @(negedge clk_int);
    chk_status("random");
    chk("random_addr_hold", bus.imem_addr, last_w[49:40]);

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    reset_n = 1'b0;
    part.delete();
    model_clear();
    @(negedge clk_int);
    chk_reset_outputs("midreset");
    bus.load_mode = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk_int);

    // strobe held high across reset release must not count as a byte
    bus.byte_strobe = 1'b1;
    bus.byte_in     = 8'hFF;
    @(negedge clk_int);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_int);
    reset_n = 1'b1;
    @(negedge clk_int);
    enter_load();
    repeat (3) @(negedge clk_int);
    bus.byte_strobe = 1'b0;
    @(negedge clk_int);
    send_word(10'h1C3, 40'h0123456789, 1);
    repeat (3) @(negedge clk_int);
    chk_status("held_strobe");

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
